// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and response payload.
package axil_pkg;

  localparam int unsigned DATA_BW = 32;
  localparam int unsigned STRB_BW = 4;
  localparam int unsigned RESP_BW = 2;

  localparam logic [RESP_BW-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_BW-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_BW-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_BW-1:0] RESP_DECERR = 2'b11;

  localparam logic [DATA_BW-1:0] TIMEOUT_RDATA = 32'hdeaddead;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } axil_state_e;

  typedef struct packed {
    logic [DATA_BW-1:0] rdata;
    logic [RESP_BW-1:0] resp;
    logic               timeout;
  } axil_rsp_t;

  // States in which the master is waiting on the slave.
  function automatic logic is_busy(axil_state_e s);
    return (s != IDLE) && (s != RSP);
  endfunction

endpackage

// File: rtl/axil_timeout.sv
// Per-transaction watchdog: counts busy cycles, flags the TIMEOUT_CYC_p-th one.
module axil_timeout #(
  parameter int unsigned TIMEOUT_CYC_p = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic expired_c
);

  localparam int unsigned CNT_BW = $clog2(TIMEOUT_CYC_p + 1);

  logic [CNT_BW-1:0] cnt_q;

  // Expiry fires on the cycle that would bring the count to TIMEOUT_CYC_p.
  assign expired_c = cnt_en && (cnt_q == CNT_BW'(TIMEOUT_CYC_p - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en && !expired_c) begin
      cnt_q <= cnt_q + CNT_BW'(1);
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite master.
// Optional watchdog enabled by macro AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned AXI_ADDR_BW_p = 12,
  parameter int unsigned TIMEOUT_CYC_p = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
  input  logic [DATA_BW-1:0]       i_cmd_wdata,
  input  logic [STRB_BW-1:0]       i_cmd_wstrb,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_BW-1:0]       o_rsp_rdata,
  output logic [RESP_BW-1:0]       o_rsp_resp,
  output logic                     o_rsp_timeout,
  output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [DATA_BW-1:0]       o_axi_wdata,
  output logic [STRB_BW-1:0]       o_axi_wstrb,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  input  logic [RESP_BW-1:0]       i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  input  logic [DATA_BW-1:0]       i_axi_rdata,
  input  logic [RESP_BW-1:0]       i_axi_rresp,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready
);

  axil_state_e              state_q, state_d;
  logic [AXI_ADDR_BW_p-1:0] addr_q, addr_d;
  logic [DATA_BW-1:0]       wdata_q, wdata_d;
  logic [STRB_BW-1:0]       wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  axil_rsp_t                rsp_q, rsp_d;
  logic                     timeout_c;

`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_timeout #(
    .TIMEOUT_CYC_p (TIMEOUT_CYC_p)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_en    (is_busy(state_q)),
    .cnt_clr   (state_q == IDLE),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (i_cmd_write) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; move on once both are gone.
        if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (i_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_d       = '{rdata: 32'd0, resp: i_axi_bresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_d       = '{rdata: i_axi_rdata, resp: i_axi_rresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abandons the AXI transaction and reports a synthetic SLVERR.
    if (timeout_c) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_d       = '{rdata: TIMEOUT_RDATA, resp: RESP_SLVERR, timeout: 1'b1};
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_q.rdata;
  assign o_rsp_resp    = rsp_q.resp;
  assign o_rsp_timeout = rsp_q.timeout;
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;

endmodule
